// File: rtl/comparador_pkg.sv
// ---------------------------------------------------------------------------
// comparador_pkg
//
// Purpose:
//   Shared definitions for the serial bit-by-bit magnitude comparator:
//   the controller state encoding, the scan-direction constants and the
//   flag-update rule applied by the single comparison cell.
//
// Contents:
//   state_t      - controller states (IDLE, RUN)
//   DIR_DER_IZQ  - right-to-left scan (LSB first)
//   DIR_IZQ_DER  - left-to-right scan (MSB first)
//   flags_t      - running comparison flags {g, l}
//   celda_update - one step of the iterative comparison cell
// ---------------------------------------------------------------------------
package comparador_pkg;

    // Controller states: waiting for a request, or walking the bits.
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Scan direction as sampled from the 'dir' input.
    localparam logic DIR_DER_IZQ = 1'b0;
    localparam logic DIR_IZQ_DER = 1'b1;

    // Running flags: g = A seen greater so far, l = A seen less so far.
    typedef struct packed {
        logic g;
        logic l;
    } flags_t;

    // One step of the comparison cell.
    // LSB-first: any differing bit overwrites the flags, so the most
    // significant difference (seen last) decides the result.
    // MSB-first: once a difference is recorded the flags freeze, so the
    // first (most significant) difference decides the result.
    function automatic flags_t celda_update(
        input logic a_i,
        input logic b_i,
        input logic g_in,
        input logic l_in,
        input logic dir
    );
        flags_t f;
        logic   frozen;
        f.g    = g_in;
        f.l    = l_in;
        frozen = (dir == DIR_IZQ_DER) && (g_in || l_in);
        if (!frozen) begin
            if (a_i && !b_i) begin
                f.g = 1'b1;
                f.l = 1'b0;
            end else if (!a_i && b_i) begin
                f.g = 1'b0;
                f.l = 1'b1;
            end
        end
        return f;
    endfunction

endpackage

// File: rtl/comparador_celda.sv
// ---------------------------------------------------------------------------
// comparador_celda
//
// Purpose:
//   Combinational iterative comparison cell. Takes one bit of each operand
//   plus the running flags and produces the updated flags. The serial
//   comparator instantiates exactly one of these and feeds it the bit
//   selected by its index counter.
//
// Ports:
//   a_i   in  1  current bit of operand A
//   b_i   in  1  current bit of operand B
//   g_in  in  1  running "A greater" flag
//   l_in  in  1  running "A less" flag
//   dir   in  1  scan direction (DIR_DER_IZQ / DIR_IZQ_DER)
//   g_out out 1  updated "A greater" flag
//   l_out out 1  updated "A less" flag
// ---------------------------------------------------------------------------
module comparador_celda
    import comparador_pkg::*;
(
    input  logic a_i,
    input  logic b_i,
    input  logic g_in,
    input  logic l_in,
    input  logic dir,
    output logic g_out,
    output logic l_out
);

    flags_t flags;

    // The update rule lives in the package so the cell and anything else
    // that needs the same behaviour share a single definition.
    always_comb begin
        flags = celda_update(a_i, b_i, g_in, l_in, dir);
    end

    assign g_out = flags.g;
    assign l_out = flags.l;

endmodule

// File: rtl/comparador_serial.sv
// ---------------------------------------------------------------------------
// comparador_serial
//
// Purpose:
//   Serial unsigned magnitude comparator. Compares two N-bit words one bit
//   per clock through a single comparison cell, scanning either LSB-first
//   or MSB-first as chosen per operation. A start/done handshake supports
//   back-to-back operations; w_out mirrors gt (A > B).
//
// Parameters:
//   N      word width in bits (N >= 1), default 8
//
// Ports:
//   clk    in  1  clock, rising edge
//   reset  in  1  synchronous reset, active low
//   start  in  1  request a comparison (accepted only in IDLE)
//   dir    in  1  0 = LSB first, 1 = MSB first; captured with start
//   a      in  N  operand A, captured with start
//   b      in  N  operand B, captured with start
//   busy   out 1  comparison in progress
//   done   out 1  one-cycle pulse, results valid
//   gt     out 1  A > B
//   lt     out 1  A < B
//   eq     out 1  A == B
//   w_out  out 1  same as gt
//
// Build option:
//   COMPARADOR_EARLY_EXIT_EN - when defined, an MSB-first scan stops on the
//   first differing bit instead of always walking all N bits.
// ---------------------------------------------------------------------------
module comparador_serial
    import comparador_pkg::*;
#(
    parameter int N = 8
)
(
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         dir,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         busy,
    output logic         done,
    output logic         gt,
    output logic         lt,
    output logic         eq,
    output logic         w_out
);

    // Index width never drops to zero, so N = 1 still has a legal counter.
    localparam int             IW       = (N > 1) ? $clog2(N) : 1;
    localparam logic [IW-1:0]  IDX_LAST = IW'(N - 1);

    state_t         state_q, state_d;
    logic [IW-1:0]  idx_q,   idx_d;
    logic           g_q,     g_d;
    logic           l_q,     l_d;
    logic [N-1:0]   a_q,     a_d;
    logic [N-1:0]   b_q,     b_d;
    logic           dir_q,   dir_d;
    logic           busy_q,  busy_d;
    logic           done_q,  done_d;
    logic           gt_q,    gt_d;
    logic           lt_q,    lt_d;
    logic           eq_q,    eq_d;

    logic           cell_g;
    logic           cell_l;
    logic           last_bit;
    logic           early_stop;

    // Single shared cell, fed by the bit the index currently points at.
    comparador_celda u_celda (
        .a_i   (a_q[idx_q]),
        .b_i   (b_q[idx_q]),
        .g_in  (g_q),
        .l_in  (l_q),
        .dir   (dir_q),
        .g_out (cell_g),
        .l_out (cell_l)
    );

    // The final bit is the MSB when counting up and bit 0 when counting down.
    assign last_bit = (dir_q == DIR_IZQ_DER) ? (idx_q == '0) : (idx_q == IDX_LAST);

    // In an MSB-first scan the first difference already fixes the answer,
    // so the optional early exit ends the run as soon as a flag is set.
`ifdef COMPARADOR_EARLY_EXIT_EN
    assign early_stop = (dir_q == DIR_IZQ_DER) && (cell_g || cell_l);
`else
    assign early_stop = 1'b0;
`endif

    // Next-state logic for the controller, datapath and registered outputs.
    // Results hold in IDLE until a new request is accepted, at which point
    // they are cleared together with the running flags.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        g_d     = g_q;
        l_d     = l_q;
        a_d     = a_q;
        b_d     = b_q;
        dir_d   = dir_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        gt_d    = gt_q;
        lt_d    = lt_q;
        eq_d    = eq_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    dir_d   = dir;
                    g_d     = 1'b0;
                    l_d     = 1'b0;
                    idx_d   = (dir == DIR_IZQ_DER) ? IDX_LAST : '0;
                    busy_d  = 1'b1;
                    gt_d    = 1'b0;
                    lt_d    = 1'b0;
                    eq_d    = 1'b0;
                    state_d = RUN;
                end
            end

            RUN: begin
                g_d = cell_g;
                l_d = cell_l;
                if (last_bit || early_stop) begin
                    // The cell output already includes this bit, so the
                    // results are taken straight from it.
                    gt_d    = cell_g;
                    lt_d    = cell_l;
                    eq_d    = ~(cell_g | cell_l);
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else if (dir_q == DIR_IZQ_DER) begin
                    idx_d = idx_q - 1'b1;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // All state and outputs are registered; a low reset aborts any run
    // in progress and clears everything back to the idle picture.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            g_q     <= 1'b0;
            l_q     <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            dir_q   <= DIR_DER_IZQ;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            gt_q    <= 1'b0;
            lt_q    <= 1'b0;
            eq_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            g_q     <= g_d;
            l_q     <= l_d;
            a_q     <= a_d;
            b_q     <= b_d;
            dir_q   <= dir_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            gt_q    <= gt_d;
            lt_q    <= lt_d;
            eq_q    <= eq_d;
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign gt    = gt_q;
    assign lt    = lt_q;
    assign eq    = eq_q;
    assign w_out = gt_q;

endmodule

// File: tb/tb_comparador_serial.sv
// ---------------------------------------------------------------------------
// tb_comparador_serial
//
// Purpose:
//   Self-checking bench for comparador_serial. An N=8 instance covers the
//   directional scans, ignored mid-run requests and mid-run reset; an N=1
//   instance covers back-to-back operation with start held high.
//   Expected results are pushed to a per-instance queue when a request is
//   driven and popped when the instance raises done.
//
// Build option:
//   COMPARADOR_EARLY_EXIT_EN changes the expected MSB-first latency.
// ---------------------------------------------------------------------------
module tb_comparador_serial;

`ifdef COMPARADOR_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    typedef struct {
        logic gt;
        logic lt;
        logic eq;
        int   lat;
    } exp_t;

    logic       clk;
    logic       reset;

    logic       start8, dir8;
    logic [7:0] a8, b8;
    logic       busy8, done8, gt8, lt8, eq8, w8;

    logic       start1, dir1;
    logic [0:0] a1, b1;
    logic       busy1, done1, gt1, lt1, eq1, w1;

    exp_t       sb8[$];
    exp_t       sb1[$];

    int         checks;
    int         errors;

    comparador_serial #(.N(8)) dut8 (
        .clk   (clk),
        .reset (reset),
        .start (start8),
        .dir   (dir8),
        .a     (a8),
        .b     (b8),
        .busy  (busy8),
        .done  (done8),
        .gt    (gt8),
        .lt    (lt8),
        .eq    (eq8),
        .w_out (w8)
    );

    comparador_serial #(.N(1)) dut1 (
        .clk   (clk),
        .reset (reset),
        .start (start1),
        .dir   (dir1),
        .a     (a1),
        .b     (b1),
        .busy  (busy1),
        .done  (done1),
        .gt    (gt1),
        .lt    (lt1),
        .eq    (eq1),
        .w_out (w1)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case something wedges the sequence.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, want finished", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    // Advance one clock and settle just past the edge, where both driving
    // and sampling happen.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected latency for N=8: always 8, except an early-exit build with
    // an MSB-first scan stops on the most significant differing bit.
    function automatic int exp_lat8(input logic [7:0] av, input logic [7:0] bv, input logic dv);
        int first_diff;
        first_diff = -1;
        for (int i = 0; i < 8; i++) begin
            if (av[i] !== bv[i]) first_diff = i;
        end
        if (EARLY && dv && first_diff >= 0) return 8 - first_diff;
        return 8;
    endfunction

    // One N=8 operation: push the expectation, capture, wait for done
    // within a bound, then pop and compare. A nonzero glitch value pulses
    // start with different operands after that many RUN edges.
    task automatic do_op8(input logic [7:0] av, input logic [7:0] bv, input logic dv,
                          input string name, input int glitch);
        exp_t e;
        int   cnt;
        bit   seen;
        e.gt  = (av > bv);
        e.lt  = (av < bv);
        e.eq  = (av == bv);
        e.lat = exp_lat8(av, bv, dv);
        sb8.push_back(e);

        a8 = av; b8 = bv; dir8 = dv; start8 = 1'b1;
        tick();
        start8 = 1'b0;

        checks++;
        if (busy8 !== 1'b1 || done8 !== 1'b0 || gt8 !== 1'b0 || lt8 !== 1'b0 || eq8 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL %s capture: busy=%b done=%b gt=%b lt=%b eq=%b, want busy=1 done=0 gt=0 lt=0 eq=0",
                     name, busy8, done8, gt8, lt8, eq8);
        end

        cnt  = 0;
        seen = 1'b0;
        while (!seen && cnt < 20) begin
            if (glitch != 0 && cnt == glitch) begin
                a8 = ~av; b8 = ~bv; dir8 = ~dv; start8 = 1'b1;
            end
            tick();
            start8 = 1'b0;
            cnt++;
            if (done8 === 1'b1) seen = 1'b1;
        end

        e = sb8.pop_front();
        checks++;
        if (!seen) begin
            errors++;
            $display("[TB] FAIL %s timeout: no done after %0d cycles, want done at %0d", name, cnt, e.lat);
        end else begin
            if (cnt != e.lat) begin
                errors++;
                $display("[TB] FAIL %s latency: got %0d cycles, want %0d", name, cnt, e.lat);
            end
            checks++;
            if (gt8 !== e.gt || lt8 !== e.lt || eq8 !== e.eq || w8 !== e.gt || busy8 !== 1'b0) begin
                errors++;
                $display("[TB] FAIL %s result: gt=%b lt=%b eq=%b w_out=%b busy=%b, want gt=%b lt=%b eq=%b w_out=%b busy=0",
                         name, gt8, lt8, eq8, w8, busy8, e.gt, e.lt, e.eq, e.gt);
            end
            tick();
            checks++;
            if (done8 !== 1'b0 || gt8 !== e.gt || lt8 !== e.lt || eq8 !== e.eq) begin
                errors++;
                $display("[TB] FAIL %s hold: done=%b gt=%b lt=%b eq=%b, want done=0 gt=%b lt=%b eq=%b",
                         name, done8, gt8, lt8, eq8, e.gt, e.lt, e.eq);
            end
        end
    endtask

    // Reset state of both instances.
    task automatic test_reset();
        reset = 1'b0;
        start8 = 1'b0; dir8 = 1'b0; a8 = '0; b8 = '0;
        start1 = 1'b0; dir1 = 1'b0; a1 = '0; b1 = '0;
        tick();
        tick();
        checks++;
        if ({busy8, done8, gt8, lt8, eq8, w8} !== 6'b0) begin
            errors++;
            $display("[TB] FAIL reset_n8: busy,done,gt,lt,eq,w_out=%b, want 000000",
                     {busy8, done8, gt8, lt8, eq8, w8});
        end
        checks++;
        if ({busy1, done1, gt1, lt1, eq1, w1} !== 6'b0) begin
            errors++;
            $display("[TB] FAIL reset_n1: busy,done,gt,lt,eq,w_out=%b, want 000000",
                     {busy1, done1, gt1, lt1, eq1, w1});
        end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_equal();
        do_op8(8'hA5, 8'hA5, 1'b0, "equal_lsb", 0);
    endtask

    // The MSB difference must win even though B wins every lower bit.
    task automatic test_msb_wins();
        do_op8(8'h80, 8'h7F, 1'b0, "msb_win_lsb", 0);
        do_op8(8'h80, 8'h7F, 1'b1, "msb_win_msb", 0);
    endtask

    task automatic test_first_diff();
        do_op8(8'h01, 8'h02, 1'b1, "first_diff_msb", 0);
        do_op8(8'h5A, 8'h5A, 1'b1, "equal_msb", 0);
        do_op8(8'h3C, 8'h1F, 1'b0, "mixed_lsb", 0);
    endtask

    // A start pulse in the 3rd RUN cycle must neither restart nor queue.
    task automatic test_start_ignored();
        int extra_done;
        do_op8(8'h3C, 8'h3D, 1'b0, "start_ignored", 2);
        extra_done = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (done8 === 1'b1 || busy8 === 1'b1) extra_done++;
        end
        checks++;
        if (extra_done != 0) begin
            errors++;
            $display("[TB] FAIL start_ignored_tail: %0d active cycles after done, want 0", extra_done);
        end
    endtask

    // Reset in the 4th RUN cycle aborts; the block then works normally.
    task automatic test_reset_midrun();
        int stray;
        a8 = 8'hF0; b8 = 8'h0F; dir8 = 1'b0; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        checks++;
        if ({busy8, done8, gt8, lt8, eq8, w8} !== 6'b0) begin
            errors++;
            $display("[TB] FAIL midrun_reset: busy,done,gt,lt,eq,w_out=%b, want 000000",
                     {busy8, done8, gt8, lt8, eq8, w8});
        end
        stray = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (done8 === 1'b1 || busy8 === 1'b1) stray++;
        end
        checks++;
        if (stray != 0) begin
            errors++;
            $display("[TB] FAIL midrun_abort: %0d active cycles after reset, want 0", stray);
        end
        do_op8(8'd3, 8'd5, 1'b0, "after_reset", 0);
    endtask

    // N=1, start held high: capture and done alternate every cycle.
    task automatic test_back_to_back();
        logic [1:0] pairs [4];
        exp_t       e;
        pairs[0] = 2'b00;
        pairs[1] = 2'b01;
        pairs[2] = 2'b10;
        pairs[3] = 2'b11;
        dir1   = 1'b0;
        start1 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a1 = pairs[i][1];
            b1 = pairs[i][0];
            e.gt  = (a1 > b1);
            e.lt  = (a1 < b1);
            e.eq  = (a1 == b1);
            e.lat = 1;
            sb1.push_back(e);
            tick();
            checks++;
            if (busy1 !== 1'b1 || done1 !== 1'b0) begin
                errors++;
                $display("[TB] FAIL b2b_capture%0d: busy=%b done=%b, want busy=1 done=0", i, busy1, done1);
            end
            tick();
            e = sb1.pop_front();
            checks++;
            if (done1 !== 1'b1 || busy1 !== 1'b0 || gt1 !== e.gt || lt1 !== e.lt || eq1 !== e.eq || w1 !== e.gt) begin
                errors++;
                $display("[TB] FAIL b2b_done%0d: done=%b busy=%b gt=%b lt=%b eq=%b w_out=%b, want done=1 busy=0 gt=%b lt=%b eq=%b w_out=%b",
                         i, done1, busy1, gt1, lt1, eq1, w1, e.gt, e.lt, e.eq, e.gt);
            end
        end
        start1 = 1'b0;
        tick();
        checks++;
        if (done1 !== 1'b0 || busy1 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL b2b_idle: done=%b busy=%b, want 0 0", done1, busy1);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_equal();
        test_msb_wins();
        test_first_diff();
        test_start_ignored();
        test_reset_midrun();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
